// File: rtl/alu_seq_if.sv
// Handshake and operand/result bundle between the control unit and alu_seq.
// The master side issues requests; the slave side (the ALU) returns results and status.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [2:0]       alu_ct;
  logic [1:0]       flag_ctl;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             busy;
  logic             done;
  logic             illegal;

  modport master (
    output start, in1, in2, alu_ct, flag_ctl,
    input  result, carry, zero, busy, done, illegal
  );

  modport slave (
    input  start, in1, in2, alu_ct, flag_ctl,
    output result, carry, zero, busy, done, illegal
  );
endinterface

// File: rtl/alu_seq.sv
// Registered execute-stage ALU: single-cycle logic/arith/shift ops plus a
// WIDTH-cycle shift-add multiplier, with persistent carry/zero flag registers.
module alu_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);

  localparam logic [2:0] OpAdd  = 3'b000;
  localparam logic [2:0] OpNand = 3'b001;
  localparam logic [2:0] OpSub  = 3'b010;
  localparam logic [2:0] OpXor  = 3'b011;
  localparam logic [2:0] OpShl  = 3'b100;
  localparam logic [2:0] OpMul  = 3'b101;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               done_q, done_d;
  logic               illegal_q, illegal_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // flag_ctl is free to change during MUL, so it is captured at start
  logic [1:0]         fctl_q, fctl_d;

  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] shl_ext;
  logic [CW-1:0]      sh_amt;
  logic [WIDTH-1:0]   op_res;
  logic               op_cy;
  logic               op_has_cy;
  logic               op_ill;
  logic [2*WIDTH-1:0] acc_step;
  logic               last_iter;

  // Single-cycle datapath: result and carry candidate for the presented opcode
  always_comb begin
    sh_amt    = bus.in2[CW-1:0];
    add_sum   = {1'b0, bus.in1} + {1'b0, bus.in2};
    // Zero-extended shift: bit WIDTH is the last bit shifted out, and any
    // amount >= WIDTH leaves the low half empty.
    shl_ext   = {{WIDTH{1'b0}}, bus.in1} << sh_amt;
    op_res    = '0;
    op_cy     = 1'b0;
    op_has_cy = 1'b0;
    op_ill    = 1'b0;
    case (bus.alu_ct)
      OpAdd: begin
        op_res    = add_sum[WIDTH-1:0];
        op_cy     = add_sum[WIDTH];
        op_has_cy = 1'b1;
      end
      OpNand: op_res = ~(bus.in1 & bus.in2);
      OpSub: begin
        op_res    = bus.in1 - bus.in2;
        op_cy     = (bus.in1 >= bus.in2);
        op_has_cy = 1'b1;
      end
      OpXor: op_res = bus.in1 ^ bus.in2;
      OpShl: begin
        op_res    = shl_ext[WIDTH-1:0];
        op_cy     = shl_ext[WIDTH];
        op_has_cy = 1'b1;
      end
      OpMul: op_ill = 1'b0;
      default: op_ill = 1'b1;
    endcase
  end

  // One shift-add multiplier iteration and the final-iteration detect
  always_comb begin
    acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
    last_iter = (cnt_q == CW'(WIDTH - 1));
  end

  // Next-state, result and flag update logic
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    fctl_d    = fctl_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.alu_ct == OpMul) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, bus.in1};
            mplier_d = bus.in2;
            cnt_d    = '0;
            fctl_d   = bus.flag_ctl;
            state_d  = StMul;
          end else begin
            done_d    = 1'b1;
            illegal_d = op_ill;
            result_d  = op_ill ? '0 : op_res;
            if (!op_ill) begin
              if (bus.flag_ctl[1] && op_has_cy) carry_d = op_cy;
              if (bus.flag_ctl[0])              zero_d  = (op_res == '0);
            end
          end
        end
      end
      StMul: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (last_iter) begin
          state_d  = StIdle;
          done_d   = 1'b1;
          result_d = acc_step[WIDTH-1:0];
          if (fctl_q[1]) carry_d = |acc_step[2*WIDTH-1:WIDTH];
          if (fctl_q[0]) zero_d  = (acc_step[WIDTH-1:0] == '0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any multiply in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      result_q  <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      fctl_q    <= '0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      fctl_q    <= fctl_d;
    end
  end

  assign bus.result  = result_q;
  assign bus.carry   = carry_q;
  assign bus.zero    = zero_q;
  assign bus.busy    = (state_q == StMul);
  assign bus.done    = done_q;
  assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, randomized ops against a
// behavioural model, and hand-written multi-cycle/reset sequences.
module tb_alu_seq;
  localparam int unsigned W  = 16;
  localparam int          NV = 15;

  logic clk = 1'b0;
  logic rst;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  fc;
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        ill;
  } vec_t;

  vec_t vecs[NV];

  int   checks = 0;
  int   errors = 0;
  logic m_carry = 1'b0;
  logic m_zero  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: arithmetic straight from the opcode definitions
  task automatic model_step(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic [1:0] fc, output logic [15:0] r, output logic ill);
    longint unsigned p;
    int              s;
    logic            has_c;
    logic            c;
    p = 0; has_c = 1'b0; c = 1'b0; ill = 1'b0; r = '0;
    case (op)
      3'd0: begin
        p = 64'(a) + 64'(b); r = p[15:0]; c = (p > 64'hFFFF); has_c = 1'b1;
      end
      3'd1: r = ~(a & b);
      3'd2: begin r = a - b; c = (a >= b); has_c = 1'b1; end
      3'd3: r = a ^ b;
      3'd4: begin
        s = int'(b[4:0]);
        p = 64'(a) * (64'd1 << s);
        r = p[15:0];
        if (s >= 1 && s <= 16) c = a[16-s];
        has_c = 1'b1;
      end
      3'd5: begin
        p = 64'(a) * 64'(b); r = p[15:0]; c = ((p >> 16) != 64'd0); has_c = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    if (!ill) begin
      if (fc[1] && has_c) m_carry = c;
      if (fc[0])          m_zero  = (r == 16'h0000);
    end
  endtask

  // Issue one request, scramble inputs while busy, wait (bounded) for done
  task automatic do_op(input string name, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [1:0] fc,
                       output logic [15:0] r, output logic c, output logic z,
                       output logic ill, output int busy_n, output int samples);
    @(negedge clk);
    bus.start = 1'b1; bus.alu_ct = op; bus.in1 = a; bus.in2 = b; bus.flag_ctl = fc;
    busy_n = 0; samples = 0;
    do begin
      @(negedge clk);
      bus.start = 1'b0;
      samples++;
      if (bus.busy) busy_n++;
      if (!bus.done) begin
        bus.in1 = 16'($urandom); bus.in2 = 16'($urandom);
        bus.alu_ct = 3'($urandom); bus.flag_ctl = 2'($urandom);
      end
    end while (!bus.done && samples < 40);
    chk({name, "_done"}, 32'(bus.done), 32'd1);
    r = bus.result; c = bus.carry; z = bus.zero; ill = bus.illegal;
    @(negedge clk);
    chk({name, "_done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    logic [15:0] r, mr, a, b;
    logic        c, z, ill, mill;
    logic [2:0]  op;
    logic [1:0]  fc;
    int          bn, ns, dones;

    //            op     a         b         fc     res       c     z     ill
    vecs[0]  = '{3'd0, 16'hFFFF, 16'h0001, 2'b11, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{3'd2, 16'h0005, 16'h0007, 2'b10, 16'hFFFE, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{3'd5, 16'h0123, 16'h0010, 2'b11, 16'h1230, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{3'd5, 16'h8000, 16'h0002, 2'b11, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{3'd4, 16'h8001, 16'h0001, 2'b11, 16'h0002, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{3'd4, 16'h8000, 16'h0010, 2'b11, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{3'd7, 16'h1234, 16'h5678, 2'b11, 16'h0000, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{3'd3, 16'hAAAA, 16'h5555, 2'b11, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3'd1, 16'hFFFF, 16'hFFFF, 2'b01, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{3'd0, 16'h7FFF, 16'h0001, 2'b11, 16'h8000, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{3'd2, 16'h0007, 16'h0005, 2'b11, 16'h0002, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{3'd6, 16'h0000, 16'h0000, 2'b11, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{3'd4, 16'h0001, 16'h0000, 2'b11, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{3'd5, 16'hFFFF, 16'hFFFF, 2'b11, 16'h0001, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{3'd0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    bus.start = 1'b0; bus.in1 = '0; bus.in2 = '0; bus.alu_ct = '0; bus.flag_ctl = '0;
    #12;
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_flags_status", {26'd0, bus.carry, bus.zero, bus.busy, bus.done, bus.illegal, 1'b0},
        32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].fc,
            r, c, z, ill, bn, ns);
      model_step(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].fc, mr, mill);
      chk($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].res));
      chk($sformatf("vec%0d_carry", i), 32'(c), 32'(vecs[i].c));
      chk($sformatf("vec%0d_zero", i), 32'(z), 32'(vecs[i].z));
      chk($sformatf("vec%0d_illegal", i), 32'(ill), 32'(vecs[i].ill));
      chk($sformatf("vec%0d_busy_cycles", i), 32'(bn), (vecs[i].op == 3'd5) ? 32'd16 : 32'd0);
      chk($sformatf("vec%0d_latency", i), 32'(ns), (vecs[i].op == 3'd5) ? 32'd17 : 32'd1);
    end

    // Randomized ops against the model
    for (int i = 0; i < 200; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 16'($urandom);
      b  = 16'($urandom);
      if (op == 3'd4 && $urandom_range(0, 1) == 1) b = 16'($urandom_range(0, 20));
      if ($urandom_range(0, 7) == 0) b = a;
      fc = 2'($urandom);
      model_step(op, a, b, fc, mr, mill);
      do_op($sformatf("rnd%0d", i), op, a, b, fc, r, c, z, ill, bn, ns);
      chk($sformatf("rnd%0d_result", i), 32'(r), 32'(mr));
      chk($sformatf("rnd%0d_carry", i), 32'(c), 32'(m_carry));
      chk($sformatf("rnd%0d_zero", i), 32'(z), 32'(m_zero));
      chk($sformatf("rnd%0d_illegal", i), 32'(ill), 32'(mill));
    end

    // MUL with stray starts while busy, then a back-to-back ADD in the done cycle
    @(negedge clk);
    bus.start = 1'b1; bus.alu_ct = 3'd5; bus.in1 = 16'h0003; bus.in2 = 16'h0005;
    bus.flag_ctl = 2'b11;
    model_step(3'd5, 16'h0003, 16'h0005, 2'b11, mr, mill);
    dones = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (bus.done) dones++;
      bus.start = (k == 3 || k == 8);
      bus.alu_ct = 3'd0; bus.in1 = 16'h1111; bus.in2 = 16'h2222; bus.flag_ctl = 2'b00;
    end
    @(negedge clk);
    chk("stray_early_dones", 32'(dones), 32'd0);
    chk("stray_mul_done", 32'(bus.done), 32'd1);
    chk("stray_mul_result", 32'(bus.result), 32'h000F);
    chk("stray_mul_carry", 32'(bus.carry), 32'(m_carry));
    bus.start = 1'b1; bus.alu_ct = 3'd0; bus.in1 = 16'h0001; bus.in2 = 16'h0002;
    bus.flag_ctl = 2'b11;
    model_step(3'd0, 16'h0001, 16'h0002, 2'b11, mr, mill);
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_done", 32'(bus.done), 32'd1);
    chk("b2b_result", 32'(bus.result), 32'h0003);
    chk("b2b_zero", 32'(bus.zero), 32'(m_zero));
    @(negedge clk);
    chk("b2b_done_pulse", 32'(bus.done), 32'd0);

    // Leave nonzero state, then reset five cycles into a MUL
    do_op("pre_rst", 3'd0, 16'hFFFF, 16'h0002, 2'b11, r, c, z, ill, bn, ns);
    model_step(3'd0, 16'hFFFF, 16'h0002, 2'b11, mr, mill);
    chk("pre_rst_result", 32'(r), 32'h0001);
    chk("pre_rst_carry", 32'(c), 32'd1);
    @(negedge clk);
    bus.start = 1'b1; bus.alu_ct = 3'd5; bus.in1 = 16'h0003; bus.in2 = 16'h0003;
    bus.flag_ctl = 2'b11;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_mul_busy", 32'(bus.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_result", 32'(bus.result), 32'd0);
    chk("async_rst_flags_status",
        {26'd0, bus.carry, bus.zero, bus.busy, bus.done, bus.illegal, 1'b0}, 32'd0);
    m_carry = 1'b0; m_zero = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("aborted_mul_dones", 32'(dones), 32'd0);
    do_op("post_rst_nand", 3'd1, 16'hFFFF, 16'hFFFF, 2'b01, r, c, z, ill, bn, ns);
    model_step(3'd1, 16'hFFFF, 16'hFFFF, 2'b01, mr, mill);
    chk("post_rst_nand_result", 32'(r), 32'h0000);
    chk("post_rst_nand_zero", 32'(z), 32'd1);
    chk("post_rst_nand_carry", 32'(c), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
